bcd_serial_addsub_ctrl: RTL
===========================

BCD_SERIAL_ADDSUB_CTRL -- requirements
Module: bcd_serial_addsub_ctrl

Interface
REQ-001 SHALL have parameter NDIGITS, default 4, giving the operand length in BCD digits (range 1..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept operands (state IDLE).
REQ-006 SHALL have port A, input, 4*NDIGITS bits: BCD minuend/augend, digit 0 in bits [3:0].
REQ-007 SHALL have port B, input, 4*NDIGITS bits: BCD subtrahend/addend.
REQ-008 SHALL have port M, input, 1 bit: mode, 0 = add, 1 = subtract.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port S, output, 4*NDIGITS bits: the BCD result.
REQ-012 SHALL have port cout, output, 1 bit: decimal carry out for add; no-borrow flag for subtract.
REQ-013 SHALL have port neg, output, 1 bit: the result is negative (sign-magnitude).
REQ-014 SHALL have port err, output, 1 bit: some A or B digit exceeded 9.

Function
REQ-015 SHALL use states IDLE, ADD, FIX and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 SHALL, on in_valid&in_ready, register A, B and M, clear the digit index, set the carry to M, set err if any input digit >9, and go to ADD.
REQ-017 SHALL, in ADD, process one digit per cycle, low digit first: if M=1, B digit replaced by its nines complement (9-d); binary sum of digit, complemented digit and carry; if sum >9, add 6 and set carry, else clear carry.
REQ-018 SHALL leave ADD after digit NDIGITS-1: cout = final carry; go to FIX if M=1, carry=0 and the macro is defined, else go to DONE.
REQ-019 SHALL, in FIX, replace S with its tens complement (nines complement of each digit, +1 carried in at digit 0), one digit per cycle, then set neg=1 and go to DONE.
REQ-020 SHALL give a latency from the accept edge to out_valid of NDIGITS cycles, or 2*NDIGITS cycles when FIX runs.
REQ-021 SHALL hold S, cout, neg and err stable in DONE until out_valid&out_ready, then go to IDLE; in_valid outside IDLE is ignored.
REQ-022 SHALL, on add overflow (e.g. 9999+0001), wrap S modulo 10^NDIGITS and set cout=1.
REQ-023 SHALL still complete the operation when an invalid digit is present (err=1); the S value in that case is unspecified but deterministic.

Reset
REQ-024 SHALL, when rst=1 at an edge, go to IDLE and clear S, cout, neg, err, the carry and the digit index; this takes priority over every other event, including mid-ADD, mid-FIX and DONE.

Configuration
REQ-025 SHALL, with BCD_SIGN_MAGNITUDE_EN defined, implement FIX and produce sign-magnitude results for negative differences.
REQ-026 SHALL, without BCD_SIGN_MAGNITUDE_EN, omit FIX and tie neg to 0; a negative difference then yields S as its tens complement with cout=0.

Structure
REQ-027 SHALL import the state enum, the BCD digit type (4 bits) and constants DIGIT_MAX=9 and BCD_CORR=6 from the shared package bcd_pkg.
REQ-028 SHALL instantiate one combinational sub-module, bcd_digit_adder (digit a, digit b, mode, carry-in -> digit sum, carry-out), reused by both ADD and FIX.

Verification
REQ-029 SHALL cover add: A=1234, B=5678, M=0 -> S=6912, cout=0, neg=0, out_valid 4 cycles after accept.
REQ-030 SHALL cover overflow: A=9999, B=0001, M=0 -> S=0000, cout=1.
REQ-031 SHALL cover positive subtract: A=5000, B=1234, M=1 -> S=3766, cout=1, neg=0.
REQ-032 SHALL cover negative subtract: A=1234, B=5000, M=1 -> with macro: S=3766, neg=1, cout=0, latency 8; without macro: S=6234, neg=0, cout=0, latency 4.
REQ-033 SHALL cover backpressure: out_ready low for 3 cycles in DONE -> S is stable, in_ready=0, and in_valid pulses are ignored; then out_ready=1 -> IDLE next cycle.
REQ-034 SHALL cover reset and error: rst asserted on the 2nd ADD cycle -> next cycle IDLE with all outputs 0; then A=12A4 -> err=1 at out_valid.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD add/subtract controller.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t DIGIT_MAX = 4'd9;
    localparam bcd_digit_t BCD_CORR  = 4'd6;

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit BCD adder; mode=1 nines-complements b so the same cell serves subtract and tens-complement.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       mode,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    bcd_digit_t b_eff;
    logic [4:0] bin;

    always_comb begin
        b_eff = mode ? (DIGIT_MAX - b) : b;
        bin   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
        if (bin > {1'b0, DIGIT_MAX}) begin
            sum  = bin[3:0] + BCD_CORR;
            cout = 1'b1;
        end else begin
            sum  = bin[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub_ctrl.sv
// Digit-serial BCD add/subtract with valid/ready handshake on both sides.
// Define BCD_SIGN_MAGNITUDE_EN to add the FIX pass that turns negative differences into sign-magnitude.
//
// state | meaning
// IDLE  | waiting for an operand set (in_ready)
// ADD   | one digit per cycle, low digit first
// FIX   | tens-complement of S for a negative difference
// DONE  | result held until out_ready
module bcd_serial_addsub_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NDIGITS-1:0] A,
    input  logic [4*NDIGITS-1:0] B,
    input  logic                 M,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NDIGITS-1:0] S,
    output logic                 cout,
    output logic                 neg,
    output logic                 err
);

    localparam int W  = 4 * NDIGITS;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    state_t         state, state_nx;
    logic [W-1:0]   a_r, b_r, s_r;
    logic           m_r, carry, cout_r, err_r;
    logic [IW-1:0]  idx;
    bcd_digit_t     sel_a, sel_b, sel_s;
    bcd_digit_t     dig_a, dig_b, dig_sum;
    logic           dig_m, dig_cout, last, in_err;
`ifdef BCD_SIGN_MAGNITUDE_EN
    logic           neg_r;
`endif

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_s = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx == IW'(i)) begin
                sel_a = a_r[i*4 +: 4];
                sel_b = b_r[i*4 +: 4];
                sel_s = s_r[i*4 +: 4];
            end
        end
        // FIX reuses the adder as 0 + (9 - s) + carry
        if (state == FIX) begin
            dig_a = '0;
            dig_b = sel_s;
            dig_m = 1'b1;
        end else begin
            dig_a = sel_a;
            dig_b = sel_b;
            dig_m = m_r;
        end
    end

    bcd_digit_adder u_digit (
        .a    (dig_a),
        .b    (dig_b),
        .mode (dig_m),
        .cin  (carry),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if ((A[i*4 +: 4] > DIGIT_MAX) || (B[i*4 +: 4] > DIGIT_MAX)) begin
                in_err = 1'b1;
            end
        end
    end

    assign last = (idx == IW'(NDIGITS - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = ADD;
            ADD: begin
                if (last) begin
`ifdef BCD_SIGN_MAGNITUDE_EN
                    state_nx = (m_r && !dig_cout) ? FIX : DONE;
`else
                    state_nx = DONE;
`endif
                end
            end
            FIX:  if (last) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            m_r    <= 1'b0;
            s_r    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            err_r  <= 1'b0;
`ifdef BCD_SIGN_MAGNITUDE_EN
            neg_r  <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= A;
                        b_r    <= B;
                        m_r    <= M;
                        idx    <= '0;
                        carry  <= M;
                        cout_r <= 1'b0;
                        err_r  <= in_err;
`ifdef BCD_SIGN_MAGNITUDE_EN
                        neg_r  <= 1'b0;
`endif
                    end
                end
                ADD: begin
                    for (int i = 0; i < NDIGITS; i++) begin
                        if (idx == IW'(i)) s_r[i*4 +: 4] <= dig_sum;
                    end
                    carry <= dig_cout;
                    idx   <= idx + IW'(1);
                    if (last) begin
                        cout_r <= dig_cout;
                        idx    <= '0;
`ifdef BCD_SIGN_MAGNITUDE_EN
                        if (m_r && !dig_cout) carry <= 1'b1;
`endif
                    end
                end
`ifdef BCD_SIGN_MAGNITUDE_EN
                FIX: begin
                    for (int i = 0; i < NDIGITS; i++) begin
                        if (idx == IW'(i)) s_r[i*4 +: 4] <= dig_sum;
                    end
                    carry <= dig_cout;
                    idx   <= idx + IW'(1);
                    if (last) begin
                        neg_r <= 1'b1;
                        idx   <= '0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign S         = s_r;
    assign cout      = cout_r;
    assign err       = err_r;
`ifdef BCD_SIGN_MAGNITUDE_EN
    assign neg       = neg_r;
`else
    assign neg       = 1'b0;
`endif

endmodule
